// File: rtl/display_page_sequencer_if.sv
// Datapath debug values in, display operands and page status out.
// The master drives the processor side; the slave is the sequencer.
interface display_page_sequencer_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_W  = 16;
  localparam int unsigned PAGE_W = 2;

  logic                ClkOut;
  logic [DATA_W-1:0]   PCResult;
  logic [DATA_W-1:0]   WriteData;
  logic [DATA_W-1:0]   HI_out;
  logic [DATA_W-1:0]   LO_out;
  logic                Hold;
  logic                Next;
  logic [NUM_W-1:0]    NumberA;
  logic [NUM_W-1:0]    NumberB;
  logic [PAGE_W-1:0]   Page;
  logic                Valid;

  modport master (
    output ClkOut, PCResult, WriteData, HI_out, LO_out, Hold, Next,
    input  NumberA, NumberB, Page, Valid
  );

  modport slave (
    input  ClkOut, PCResult, WriteData, HI_out, LO_out, Hold, Next,
    output NumberA, NumberB, Page, Valid
  );
endinterface

// File: rtl/display_page_sequencer.sv
// Snapshots Datapath debug registers on each divided-clock tick and pages
// through them on the 8-digit display, advancing on a dwell timer or Next.
module display_page_sequencer #(
  parameter int unsigned DWELL_CYCLES = 200000000,
  parameter int unsigned CNT_W        = 28
) (
  input  logic                     Clk,
  input  logic                     Reset,
  display_page_sequencer_if.slave  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_W  = 16;
  localparam int unsigned N_PAGE = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    PG_PC = 2'd0,
    PG_WD = 2'd1,
    PG_HI = 2'd2,
    PG_LO = 2'd3
  } page_e;

  logic                          clk_s1_q, clk_s2_q, clk_s3_q;
  logic                          clk_s1_d, clk_s2_d, clk_s3_d;
  logic                          nxt_s1_q, nxt_s2_q, nxt_s3_q;
  logic                          nxt_s1_d, nxt_s2_d, nxt_s3_d;
  logic [N_PAGE-1:0][DATA_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  page_e                         page_q, page_d, page_adv_c;
  logic [NUM_W-1:0]              num_a_q, num_a_d;
  logic [NUM_W-1:0]              num_b_q, num_b_d;
  logic                          valid_q, valid_d;
  logic                          tick_c, next_tick_c, dwell_done_c;

  always_comb begin
    unique case (page_q)
      PG_PC:   page_adv_c = PG_WD;
      PG_WD:   page_adv_c = PG_HI;
      PG_HI:   page_adv_c = PG_LO;
      PG_LO:   page_adv_c = PG_PC;
      default: page_adv_c = PG_PC;
    endcase
  end

  always_comb begin
    clk_s1_d = bus.ClkOut;
    clk_s2_d = clk_s1_q;
    clk_s3_d = clk_s2_q;
    nxt_s1_d = bus.Next;
    nxt_s2_d = nxt_s1_q;
    nxt_s3_d = nxt_s2_q;
    snap_d   = snap_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    page_d   = page_q;

    tick_c       = clk_s2_q & ~clk_s3_q;
    next_tick_c  = nxt_s2_q & ~nxt_s3_q;
    dwell_done_c = ~bus.Hold & (cnt_q == CNT_MAX);

    if (tick_c) begin
      snap_d[PG_PC] = bus.PCResult;
      snap_d[PG_WD] = bus.WriteData;
      snap_d[PG_HI] = bus.HI_out;
      snap_d[PG_LO] = bus.LO_out;
      valid_d       = 1'b1;
    end

    // A Next edge coinciding with dwell expiry still advances only once.
    if (next_tick_c || dwell_done_c) begin
      cnt_d  = '0;
      page_d = page_adv_c;
    end else if (!bus.Hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    num_a_d = snap_q[page_q][DATA_W-1:NUM_W];
    num_b_d = snap_q[page_q][NUM_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      nxt_s1_q <= 1'b0;
      nxt_s2_q <= 1'b0;
      nxt_s3_q <= 1'b0;
      snap_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      page_q   <= PG_PC;
      num_a_q  <= '0;
      num_b_q  <= '0;
    end else begin
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      clk_s3_q <= clk_s3_d;
      nxt_s1_q <= nxt_s1_d;
      nxt_s2_q <= nxt_s2_d;
      nxt_s3_q <= nxt_s3_d;
      snap_q   <= snap_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      num_a_q  <= num_a_d;
      num_b_q  <= num_b_d;
    end
  end

  assign bus.NumberA = num_a_q;
  assign bus.NumberB = num_b_q;
  assign bus.Page    = page_q;
  assign bus.Valid   = valid_q;
endmodule

// File: tb/tb_display_page_sequencer.sv
// Directed bench for display_page_sequencer with an 8-cycle dwell.
module tb_display_page_sequencer;
  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  page;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;
  exp_t sb[$];

  display_page_sequencer_if bus ();

  display_page_sequencer #(.DWELL_CYCLES(8), .CNT_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.NumberA !== 16'h0 || bus.NumberB !== 16'h0) begin
      errors++;
      $display("FAIL reset_numbers: got %h/%h want 0000/0000", bus.NumberA, bus.NumberB);
    end
    checks++;
    if (bus.Page !== 2'd0) begin
      errors++;
      $display("FAIL reset_page: got %0d want 0", bus.Page);
    end
    checks++;
    if (bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", bus.Valid);
    end
  endtask

  task automatic test_capture();
    bus.PCResult  = 32'h0040_0010;
    bus.WriteData = 32'h1234_5678;
    bus.HI_out    = 32'hDEAD_BEEF;
    bus.LO_out    = 32'h0000_CAFE;
    bus.ClkOut    = 1'b1;
    sb.push_back('{cyc: 4, page: 2'd0, a: 16'h0040, b: 16'h0010});
    step(2);
    checks++;
    if (bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL capture_early_valid: got %b want 0", bus.Valid);
    end
    step(1);
    checks++;
    if (bus.Valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_valid: got %b want 1", bus.Valid);
    end
    checks++;
    if (bus.NumberA !== 16'h0000 || bus.NumberB !== 16'h0000) begin
      errors++;
      $display("FAIL capture_latency: got %h/%h want 0000/0000", bus.NumberA, bus.NumberB);
    end
    step(1);
    begin
      exp_t e = sb.pop_front();
      checks++;
      if (bus.Page !== e.page || bus.NumberA !== e.a || bus.NumberB !== e.b) begin
        errors++;
        $display("FAIL capture_show: got p%0d %h/%h want p%0d %h/%h",
                 bus.Page, bus.NumberA, bus.NumberB, e.page, e.a, e.b);
      end
    end
    bus.ClkOut = 1'b0;
  endtask

  task automatic test_dwell();
    sb.push_back('{cyc:  7, page: 2'd0, a: 16'h0040, b: 16'h0010});
    sb.push_back('{cyc:  8, page: 2'd1, a: 16'h0040, b: 16'h0010});
    sb.push_back('{cyc:  9, page: 2'd1, a: 16'h1234, b: 16'h5678});
    sb.push_back('{cyc: 15, page: 2'd1, a: 16'h1234, b: 16'h5678});
    sb.push_back('{cyc: 16, page: 2'd2, a: 16'h1234, b: 16'h5678});
    sb.push_back('{cyc: 17, page: 2'd2, a: 16'hDEAD, b: 16'hBEEF});
    sb.push_back('{cyc: 24, page: 2'd3, a: 16'hDEAD, b: 16'hBEEF});
    sb.push_back('{cyc: 25, page: 2'd3, a: 16'h0000, b: 16'hCAFE});
    sb.push_back('{cyc: 32, page: 2'd0, a: 16'h0000, b: 16'hCAFE});
    sb.push_back('{cyc: 33, page: 2'd0, a: 16'h0040, b: 16'h0010});
    bus.Hold = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      step(1);
      if (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e = sb.pop_front();
        checks++;
        if (bus.Page !== e.page || bus.NumberA !== e.a || bus.NumberB !== e.b) begin
          errors++;
          $display("FAIL dwell_c%0d: got p%0d %h/%h want p%0d %h/%h", k,
                   bus.Page, bus.NumberA, bus.NumberB, e.page, e.a, e.b);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL dwell_leftover: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_hold();
    step(4);
    bus.Hold = 1'b1;
    step(20);
    checks++;
    if (bus.Page !== 2'd0) begin
      errors++;
      $display("FAIL hold_frozen: got %0d want 0", bus.Page);
    end
    bus.Hold = 1'b0;
    step(2);
    checks++;
    if (bus.Page !== 2'd0) begin
      errors++;
      $display("FAIL hold_resume_early: got %0d want 0", bus.Page);
    end
    step(1);
    checks++;
    if (bus.Page !== 2'd1) begin
      errors++;
      $display("FAIL hold_resume: got %0d want 1", bus.Page);
    end
  endtask

  task automatic test_next_collision();
    step(5);
    bus.Next = 1'b1;
    step(2);
    checks++;
    if (bus.Page !== 2'd1) begin
      errors++;
      $display("FAIL collide_before: got %0d want 1", bus.Page);
    end
    step(1);
    checks++;
    if (bus.Page !== 2'd2) begin
      errors++;
      $display("FAIL collide_once: got %0d want 2", bus.Page);
    end
    step(7);
    checks++;
    if (bus.Page !== 2'd2) begin
      errors++;
      $display("FAIL collide_cnt_clear: got %0d want 2", bus.Page);
    end
    step(1);
    checks++;
    if (bus.Page !== 2'd3) begin
      errors++;
      $display("FAIL collide_next_dwell: got %0d want 3", bus.Page);
    end
    bus.Next = 1'b0;
  endtask

  task automatic test_next_hold();
    step(3);
    bus.Hold = 1'b1;
    bus.Next = 1'b1;
    step(2);
    checks++;
    if (bus.Page !== 2'd3) begin
      errors++;
      $display("FAIL next_hold_early: got %0d want 3", bus.Page);
    end
    step(1);
    checks++;
    if (bus.Page !== 2'd0) begin
      errors++;
      $display("FAIL next_hold_wrap: got %0d want 0", bus.Page);
    end
    bus.Next = 1'b0;
    step(3);
  endtask

  task automatic test_hold_capture();
    bus.PCResult = 32'h0000_0000;
    bus.ClkOut   = 1'b1;
    step(4);
    checks++;
    if (bus.NumberA !== 16'h0000 || bus.NumberB !== 16'h0000) begin
      errors++;
      $display("FAIL hold_cap_zero: got %h/%h want 0000/0000", bus.NumberA, bus.NumberB);
    end
    bus.ClkOut = 1'b0;
    step(3);
    bus.PCResult = 32'h0000_0004;
    bus.ClkOut   = 1'b1;
    step(4);
    checks++;
    if (bus.NumberA !== 16'h0000 || bus.NumberB !== 16'h0004) begin
      errors++;
      $display("FAIL hold_cap_four: got %h/%h want 0000/0004", bus.NumberA, bus.NumberB);
    end
    checks++;
    if (bus.Page !== 2'd0) begin
      errors++;
      $display("FAIL hold_cap_page: got %0d want 0", bus.Page);
    end
    bus.ClkOut = 1'b0;
  endtask

  task automatic test_reset_mid();
    step(3);
    bus.Next = 1'b1;
    step(3);
    bus.Next = 1'b0;
    step(3);
    bus.Next = 1'b1;
    step(3);
    checks++;
    if (bus.Page !== 2'd2) begin
      errors++;
      $display("FAIL mid_setup_page: got %0d want 2", bus.Page);
    end
    bus.Next = 1'b0;
    Reset    = 1'b1;
    #1;
    checks++;
    if (bus.NumberA !== 16'h0 || bus.NumberB !== 16'h0 || bus.Page !== 2'd0 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got p%0d %h/%h v%b want p0 0000/0000 v0",
               bus.Page, bus.NumberA, bus.NumberB, bus.Valid);
    end
    step(2);
    Reset    = 1'b0;
    bus.Hold = 1'b0;
    step(20);
    checks++;
    if (bus.NumberA !== 16'h0 || bus.NumberB !== 16'h0 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release: got %h/%h v%b want 0000/0000 v0",
               bus.NumberA, bus.NumberB, bus.Valid);
    end
    checks++;
    if (bus.Page !== 2'd2) begin
      errors++;
      $display("FAIL mid_restart_page: got %0d want 2", bus.Page);
    end
  endtask

  initial begin
    Reset         = 1'b1;
    bus.ClkOut    = 1'b0;
    bus.PCResult  = '0;
    bus.WriteData = '0;
    bus.HI_out    = '0;
    bus.LO_out    = '0;
    bus.Hold      = 1'b1;
    bus.Next      = 1'b0;
    step(2);
    test_reset();
    Reset = 1'b0;
    test_capture();
    test_dwell();
    test_hold();
    test_next_collision();
    test_next_hold();
    test_hold_capture();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
